// File: rtl/ghost_motion_if.sv
// rtl/ghost_motion_if.sv - controller-facing step/direction/capture bundle for ghost_motion
interface ghost_motion_if;
  logic        move_tick;
  logic [3:0]  move_direction;
  logic        caught;
  logic [10:0] ghost_pos_x;
  logic [9:0]  ghost_pos_y;
  logic [3:0]  prev_direction;
  logic        at_tile;
  logic        moved;
  logic [1:0]  state;

  modport master (
    output move_tick, move_direction, caught,
    input  ghost_pos_x, ghost_pos_y, prev_direction, at_tile, moved, state
  );

  modport slave (
    input  move_tick, move_direction, caught,
    output ghost_pos_x, ghost_pos_y, prev_direction, at_tile, moved, state
  );
endinterface

// File: rtl/ghost_motion.sv
// rtl/ghost_motion.sv - pixel-stepped ghost position FSM (HOME/MOVE/RESPAWN)
// Optional horizontal tunnel wrap at the x limits: define GHOST_TUNNEL_WRAP_EN.
module ghost_motion #(
  parameter logic [10:0] START_X       = 11'd320,
  parameter logic [9:0]  START_Y       = 10'd240,
  parameter logic [10:0] X_MIN         = 11'd0,
  parameter logic [10:0] X_MAX         = 11'd632,
  parameter logic [9:0]  Y_MAX         = 10'd472,
  parameter logic [7:0]  RELEASE_TICKS = 8'd32,
  parameter logic [7:0]  RESPAWN_TICKS = 8'd64
) (
  input logic         clk,
  input logic         rst_n,
  ghost_motion_if.slave gm
);

  typedef enum logic [1:0] {
    HOME    = 2'b00,
    MOVE    = 2'b01,
    RESPAWN = 2'b10
  } state_t;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [3:0]  dir_q, dir_d;
  logic [3:0]  prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        moved_q, moved_d;

  logic        at_tile;
  logic [11:0] x_inc, x_dec;
  logic [10:0] y_inc, y_dec;
  logic [3:0]  step_dir;
  logic        stepped;

  assign at_tile = (x_q[2:0] == 3'd0) && (y_q[2:0] == 3'd0);
  // One extra bit so a decrement from 0 shows up as a set MSB.
  assign x_inc   = {1'b0, x_q} + 12'd1;
  assign x_dec   = {1'b0, x_q} - 12'd1;
  assign y_inc   = {1'b0, y_q} + 11'd1;
  assign y_dec   = {1'b0, y_q} - 11'd1;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    moved_d  = 1'b0;
    step_dir = 4'b0000;
    stepped  = 1'b0;

    if (gm.caught) begin
      state_d = RESPAWN;
      x_d     = START_X;
      y_d     = START_Y;
      dir_d   = 4'b0000;
      cnt_d   = 8'd0;
      moved_d = 1'b1;
    end else if (gm.move_tick) begin
      case (state_q)
        HOME: begin
          if (cnt_q == RELEASE_TICKS - 8'd1) begin
            state_d = MOVE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RESPAWN: begin
          if (cnt_q == RESPAWN_TICKS - 8'd1) begin
            state_d = MOVE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        MOVE: begin
          // Direction requests are only honoured on tile boundaries.
          if (at_tile) begin
            step_dir = $onehot(gm.move_direction) ? gm.move_direction : 4'b0000;
          end else begin
            step_dir = dir_q;
          end
          dir_d = step_dir;
          case (step_dir)
            DIR_RIGHT: begin
              if (x_inc > {1'b0, X_MAX}) begin
`ifdef GHOST_TUNNEL_WRAP_EN
                x_d     = X_MIN;
                stepped = 1'b1;
`else
                dir_d   = 4'b0000;
`endif
              end else begin
                x_d     = x_inc[10:0];
                stepped = 1'b1;
              end
            end
            DIR_LEFT: begin
              if (x_dec[11] || (x_dec < {1'b0, X_MIN})) begin
`ifdef GHOST_TUNNEL_WRAP_EN
                x_d     = X_MAX;
                stepped = 1'b1;
`else
                dir_d   = 4'b0000;
`endif
              end else begin
                x_d     = x_dec[10:0];
                stepped = 1'b1;
              end
            end
            DIR_UP: begin
              if (y_dec[10]) begin
                dir_d = 4'b0000;
              end else begin
                y_d     = y_dec[9:0];
                stepped = 1'b1;
              end
            end
            DIR_DOWN: begin
              if (y_inc > {1'b0, Y_MAX}) begin
                dir_d = 4'b0000;
              end else begin
                y_d     = y_inc[9:0];
                stepped = 1'b1;
              end
            end
            default: dir_d = 4'b0000;
          endcase
          if (stepped) begin
            moved_d = 1'b1;
            prev_d  = step_dir;
          end
        end
        default: state_d = HOME;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOME;
      x_q     <= START_X;
      y_q     <= START_Y;
      dir_q   <= 4'b0000;
      prev_q  <= 4'b0000;
      cnt_q   <= 8'd0;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      moved_q <= moved_d;
    end
  end

  assign gm.ghost_pos_x    = x_q;
  assign gm.ghost_pos_y    = y_q;
  assign gm.prev_direction = prev_q;
  assign gm.at_tile        = at_tile;
  assign gm.moved          = moved_q;
  assign gm.state          = state_q;

endmodule
